// File: rtl/s526_resp_misr.sv
// Response compactor for the s526 benchmark: a 16-bit MISR folds n_cycles valid 6-bit responses.
// Define S526_RESP_MISR_GOLDEN_CMP_EN to add the golden-signature register and comparator.
module s526_resp_misr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] n_cycles,
    input  logic [15:0] golden,
    input  logic        resp_valid,
    input  logic [5:0]  resp,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature,
    output logic        pass
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] sig_q, sig_d;
    logic [15:0] cnt_q, cnt_d;
    logic        load;

    // Polynomial x^16+x^14+x^13+x^11+1, response folded into the low six bits.
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [5:0] r);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb} ^ {10'b0, r};
    endfunction

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    load    = 1'b1;
                    sig_d   = SEED;
                    cnt_d   = n_cycles;
                    state_d = (n_cycles == 16'd0) ? StDone : StRun;
                end
            end
            StRun: begin
                // Gaps in resp_valid stall both the signature and the beat counter.
                if (resp_valid) begin
                    sig_d = misr_step(sig_q, resp);
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sig_q   <= SEED;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign signature = sig_q;

`ifdef S526_RESP_MISR_GOLDEN_CMP_EN
    logic [15:0] golden_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            golden_q <= 16'd0;
        end else if (load) begin
            golden_q <= golden;
        end
    end

    assign pass = done && (sig_q == golden_q);
`else
    logic unused_golden;

    assign unused_golden = ^{golden, load};
    assign pass          = 1'b0;
`endif

endmodule

// File: tb/tb_s526_resp_misr.sv
// Directed self-checking bench for s526_resp_misr; expected signatures are hand-computed.
module tb_s526_resp_misr;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] n_cycles;
    logic [15:0] golden;
    logic        resp_valid;
    logic [5:0]  resp;
    logic        busy;
    logic        done;
    logic [15:0] signature;
    logic        pass;

    int checks   = 0;
    int failures = 0;
    logic exp_pass_en;

    always #5 clk = ~clk;

    s526_resp_misr dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .n_cycles   (n_cycles),
        .golden     (golden),
        .resp_valid (resp_valid),
        .resp       (resp),
        .busy       (busy),
        .done       (done),
        .signature  (signature),
        .pass       (pass)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n, input logic [15:0] g);
        start    = 1'b1;
        n_cycles = n;
        golden   = g;
        tick();
        start    = 1'b0;
    endtask

    task automatic beat(input logic [5:0] r);
        resp_valid = 1'b1;
        resp       = r;
        tick();
        resp_valid = 1'b0;
        resp       = 6'h00;
    endtask

    initial begin
`ifdef S526_RESP_MISR_GOLDEN_CMP_EN
        exp_pass_en = 1'b1;
`else
        exp_pass_en = 1'b0;
`endif
        rst        = 1'b1;
        start      = 1'b1;
        n_cycles   = 16'd0;
        golden     = 16'h0000;
        resp_valid = 1'b0;
        resp       = 6'h00;
        tick();
        tick();
        check("rst_busy", {15'b0, busy}, 16'd0);
        check("rst_done", {15'b0, done}, 16'd0);
        check("rst_pass", {15'b0, pass}, 16'd0);
        check("rst_sig", signature, 16'hACE1);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("idle_busy", {15'b0, busy}, 16'd0);

        // Zero-length run goes straight to DONE with the seed.
        do_start(16'd0, 16'hACE1);
        check("n0_done", {15'b0, done}, 16'd1);
        check("n0_busy", {15'b0, busy}, 16'd0);
        check("n0_sig", signature, 16'hACE1);
        check("n0_pass", {15'b0, pass}, {15'b0, exp_pass_en});

        // Single beat of zeros.
        do_start(16'd1, 16'h0000);
        check("b00_busy", {15'b0, busy}, 16'd1);
        check("b00_nodone", {15'b0, done}, 16'd0);
        beat(6'h00);
        check("b00_done", {15'b0, done}, 16'd1);
        check("b00_sig", signature, 16'h59C3);
        check("b00_pass", {15'b0, pass}, 16'd0);
        // DONE ignores further responses.
        beat(6'h3F);
        check("done_hold_sig", signature, 16'h59C3);
        check("done_hold_done", {15'b0, done}, 16'd1);

        // Restart from DONE reloads the seed; matching golden.
        do_start(16'd1, 16'h59FC);
        check("restart_sig", signature, 16'hACE1);
        check("restart_busy", {15'b0, busy}, 16'd1);
        check("restart_pass", {15'b0, pass}, 16'd0);
        beat(6'h3F);
        check("b3f_sig", signature, 16'h59FC);
        check("b3f_done", {15'b0, done}, 16'd1);
        check("gold_pass", {15'b0, pass}, {15'b0, exp_pass_en});

        // Mismatching golden.
        do_start(16'd1, 16'h59FD);
        beat(6'h3F);
        check("bad_gold_sig", signature, 16'h59FC);
        check("bad_gold_pass", {15'b0, pass}, 16'd0);

        // Gap of three idle cycles before the only beat.
        do_start(16'd1, 16'h0000);
        resp = 6'h3F;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gap_busy", {15'b0, busy}, 16'd1);
            check("gap_sig", signature, 16'hACE1);
        end
        beat(6'h3F);
        check("gap_final_sig", signature, 16'h59FC);
        check("gap_done", {15'b0, done}, 16'd1);

        // Start during RUN is ignored (n_cycles=0 would otherwise finish at once).
        do_start(16'd2, 16'h0000);
        tick();
        do_start(16'd0, 16'h0000);
        check("run_start_busy", {15'b0, busy}, 16'd1);
        check("run_start_sig", signature, 16'hACE1);
        beat(6'h3F);
        check("two_b1_busy", {15'b0, busy}, 16'd1);
        check("two_b1_sig", signature, 16'h59FC);
        beat(6'h00);
        check("two_b2_done", {15'b0, done}, 16'd1);
        check("two_b2_sig", signature, 16'hB3F9);

        // Abort a long run with reset at beat 50.
        do_start(16'd100, 16'h0000);
        for (int i = 0; i < 50; i++) begin
            beat(6'(i));
        end
        check("long_busy", {15'b0, busy}, 16'd1);
        rst        = 1'b1;
        resp_valid = 1'b1;
        resp       = 6'h05;
        tick();
        rst        = 1'b0;
        resp_valid = 1'b0;
        check("abort_busy", {15'b0, busy}, 16'd0);
        check("abort_done", {15'b0, done}, 16'd0);
        check("abort_sig", signature, 16'hACE1);
        for (int i = 0; i < 3; i++) begin
            beat(6'h2A);
            check("abort_no_done", {15'b0, done}, 16'd0);
            check("abort_idle_sig", signature, 16'hACE1);
        end
        do_start(16'd1, 16'h59FC);
        beat(6'h3F);
        check("after_abort_sig", signature, 16'h59FC);
        check("after_abort_done", {15'b0, done}, 16'd1);
        check("after_abort_pass", {15'b0, pass}, {15'b0, exp_pass_en});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
